ucaspian_time_ctrl: RTL and testbench

- Parametrised network time-step controller for the uCaspian core.
- Accumulates run-length requests into a target time and detects when all N processing units are quiescent.
- Issues one-cycle next_step pulses and advances the core time counter.
- Reports each new time to the host-side interface through a set/clear update flag.

---
 rtl/ucaspian_time_pkg.sv | 28 ++
 rtl/ucaspian_quiet_detect.sv | 65 ++++++
 rtl/ucaspian_time_ctrl.sv | 142 ++++++++++++++
 tb/tb_ucaspian_time_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucaspian_time_pkg.sv
// ----------------------------------------------------------------------------
// ucaspian_time_pkg
// Shared types and constants for the uCaspian network time-step controller.
//   time_state_t : controller FSM states (IDLE, WAIT, STEP, BLANK)
//   utime_t      : core time value at the default 32-bit width
//   TIME_MAX     : largest representable default-width time
//   cnt_width()  : width needed for a saturating 0..hold counter (min 1 bit)
// ----------------------------------------------------------------------------
package ucaspian_time_pkg;

    localparam int TIME_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEP  = 2'd2,
        BLANK = 2'd3
    } time_state_t;

    typedef logic [TIME_W_DEF-1:0] utime_t;

    localparam utime_t TIME_MAX = '1;

    function automatic int cnt_width(input int hold);
        return (hold > 0) ? $clog2(hold + 1) : 1;
    endfunction

endpackage

// File: rtl/ucaspian_quiet_detect.sv
// ----------------------------------------------------------------------------
// ucaspian_quiet_detect
// Decides when every processing unit has been quiescent long enough to step.
// Ports:
//   clk, reset (async, active-low), clear (sync)
//   blank          : counter held at zero (step pulse and the cycle after it)
//   unit_step_done : per-unit quiescent flags, N_UNITS wide
//   quiet          : all units done now and for HOLD_CYCLES cycles before
// ----------------------------------------------------------------------------
module ucaspian_quiet_detect
    import ucaspian_time_pkg::*;
#(
    parameter int N_UNITS     = 6,
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               blank,
    input  logic [N_UNITS-1:0] unit_step_done,
    output logic               quiet
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    logic [N_UNITS:0] and_chain;
    logic             all_done;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign and_chain[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_and
            assign and_chain[gi+1] = and_chain[gi] & unit_step_done[gi];
        end
    endgenerate

    assign all_done = and_chain[N_UNITS];

    // Counts consecutive all-done cycles, saturating at HOLD_CYCLES. The blank
    // window keeps it at zero so units have time to drop their done flags.
    always_comb begin
        count_next = count_reg;
        if (blank || !all_done) begin
            count_next = '0;
        end else if (count_reg != HOLD_MAX) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign quiet = all_done && (count_reg == HOLD_MAX) && !blank;

endmodule

// File: rtl/ucaspian_time_ctrl.sv
// ----------------------------------------------------------------------------
// ucaspian_time_ctrl
// Network time-step controller: accumulates run-length requests into a
// saturating target time, steps the core time whenever all units are quiet,
// and flags every new time for the host.
// Ports:
//   clk, reset (async, active-low), clear (sync clear of run state)
//   unit_step_done[N_UNITS] : per-unit quiescent flags
//   target_value/vld/rdy    : run-length request handshake
//   next_step               : one-cycle step pulse to all units
//   time_current            : core time
//   time_remaining          : registered (target > core time)
//   time_update / time_sent : new-time flag and host acknowledge
//   busy                    : FSM not IDLE
// Build option: UCASPIAN_TIME_BACKPRESSURE_EN -- when defined, no step is
// taken while the previous time is still unreported (time_update=1).
// ----------------------------------------------------------------------------
module ucaspian_time_ctrl
    import ucaspian_time_pkg::*;
#(
    parameter int TIME_W      = 32,
    parameter int TGT_W       = 8,
    parameter int N_UNITS     = 6,
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [N_UNITS-1:0] unit_step_done,
    input  logic [TGT_W-1:0]   target_value,
    input  logic               target_vld,
    output logic               target_rdy,
    output logic               next_step,
    output logic [TIME_W-1:0]  time_current,
    output logic               time_remaining,
    output logic               time_update,
    input  logic               time_sent,
    output logic               busy
);

    localparam logic [TIME_W-1:0] TIME_LIMIT = {TIME_W{1'b1}};

    time_state_t       state_reg, state_next;
    logic [TIME_W-1:0] target_reg, target_next;
    logic [TIME_W-1:0] time_reg;
    logic              remaining_reg;
    logic              update_reg;
    logic              rdy_reg;
    logic              quiet;
    logic              blank;
    logic              step_ok;
    logic              accept;
    logic [TIME_W:0]   target_sum;

    assign blank = (state_reg == STEP) || (state_reg == BLANK);

    ucaspian_quiet_detect #(
        .N_UNITS     (N_UNITS),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_quiet (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .blank          (blank),
        .unit_step_done (unit_step_done),
        .quiet          (quiet)
    );

`ifdef UCASPIAN_TIME_BACKPRESSURE_EN
    assign step_ok = quiet && !update_reg;
`else
    assign step_ok = quiet;
`endif

    // rdy_reg only remembers that reset has been released; clear gates it
    // combinationally so the request port reopens the cycle clear drops.
    assign target_rdy = rdy_reg && !clear;
    assign accept     = target_vld && target_rdy;

    // One extra bit catches the carry so the target clamps instead of wrapping.
    assign target_sum = {1'b0, target_reg} + (TIME_W+1)'(target_value);

    always_comb begin
        target_next = target_reg;
        if (accept) begin
            target_next = target_sum[TIME_W] ? TIME_LIMIT : target_sum[TIME_W-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (remaining_reg) state_next = WAIT;
            end
            WAIT: begin
                if (!remaining_reg) state_next = IDLE;
                else if (step_ok)   state_next = STEP;
            end
            STEP:    state_next = BLANK;
            BLANK:   state_next = WAIT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            target_reg    <= '0;
            time_reg      <= '0;
            remaining_reg <= 1'b0;
            update_reg    <= 1'b0;
            rdy_reg       <= 1'b0;
        end else begin
            rdy_reg <= 1'b1;
            if (clear) begin
                state_reg     <= IDLE;
                target_reg    <= '0;
                time_reg      <= '0;
                remaining_reg <= 1'b0;
                update_reg    <= 1'b0;
            end else begin
                state_reg     <= state_next;
                target_reg    <= target_next;
                remaining_reg <= (target_reg > time_reg);
                if (state_reg == STEP) begin
                    time_reg   <= time_reg + 1'b1;
                    update_reg <= 1'b1;
                end else if (time_sent) begin
                    update_reg <= 1'b0;
                end
            end
        end
    end

    assign next_step      = (state_reg == STEP);
    assign time_current   = time_reg;
    assign time_remaining = remaining_reg;
    assign time_update    = update_reg;
    assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_ucaspian_time_ctrl.sv
module tb_ucaspian_time_ctrl;

    localparam int TIME_W = 8;
    localparam int TGT_W  = 8;
    localparam int NU     = 6;
    localparam int HOLD   = 1;
    localparam logic [NU-1:0] ALL_DONE = '1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clear = 1'b0;
    logic [NU-1:0]     done = '1;
    logic [TGT_W-1:0]  tv = '0;
    logic              vld = 1'b0;
    logic              sent = 1'b1;
    logic              target_rdy, next_step, time_remaining, time_update, busy;
    logic [TIME_W-1:0] time_current;

    ucaspian_time_ctrl #(
        .TIME_W(TIME_W), .TGT_W(TGT_W), .N_UNITS(NU), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .unit_step_done(done),
        .target_value(tv), .target_vld(vld), .target_rdy(target_rdy),
        .next_step(next_step), .time_current(time_current),
        .time_remaining(time_remaining), .time_update(time_update),
        .time_sent(sent), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_cyc    = 0;
    int pulses   = 0;

    logic s_step, s_rem, s_upd, s_rdy, s_busy;
    logic [TIME_W-1:0] s_time;
    int s_cyc;

    typedef struct {
        int a;
        int b;
        int exp_time;
    } run_vec_t;

    run_vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n_cyc);
        end
    endtask

    // Sample the current cycle's outputs on the falling edge, then advance
    // past the next rising edge so new inputs can be driven.
    task automatic cyc();
        @(negedge clk);
        s_step = next_step; s_time = time_current; s_rem = time_remaining;
        s_upd = time_update; s_rdy = target_rdy; s_busy = busy; s_cyc = n_cyc;
        if (s_step) pulses++;
        @(posedge clk);
        #1;
        n_cyc++;
    endtask

    task automatic clr();
        clear = 1'b1; cyc(); clear = 1'b0;
    endtask

    task automatic accept(input int v);
        vld = 1'b1; tv = TGT_W'(v); cyc(); vld = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int idle_run = 0;
        int k = 0;
        while (idle_run < 3 && k < budget) begin
            cyc(); k++;
            if (!s_busy && !s_rem) idle_run++;
            else idle_run = 0;
        end
        chk(name, (k < budget) ? 1 : 0, 1);
    endtask

    task automatic wait_pulse(input string name, input int budget, output int waited);
        waited = 0;
        do begin
            cyc(); waited++;
        end while (!s_step && waited < budget);
        chk(name, s_step, 1);
    endtask

    initial begin
        int a_cyc, p1, p2, p3, w, base, found;
        int m_target, m_time, m_rem, m_upd, prev_upd, last_low, last_step, last_clear, t;
        int r_clear, r_vld, r_sent, r_tv;

        vecs[0] = '{3, 0, 3};
        vecs[1] = '{200, 100, 255};
        vecs[2] = '{0, 0, 0};
        vecs[3] = '{5, 0, 5};
        vecs[4] = '{0, 7, 7};
        vecs[5] = '{255, 255, 255};

        // ---- reset values ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_next_step", next_step, 0);
        chk("rst_time", time_current, 0);
        chk("rst_remaining", time_remaining, 0);
        chk("rst_update", time_update, 0);
        chk("rst_rdy", target_rdy, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // ---- basic run: target 3, exact pulse spacing ----
        cyc();
        accept(3);
        chk("basic_rdy", s_rdy, 1);
        a_cyc = s_cyc; base = pulses - 0;
        wait_pulse("basic_p1", 20, w); p1 = s_cyc;
        wait_pulse("basic_p2", 20, w); p2 = s_cyc;
        wait_pulse("basic_p3", 20, w); p3 = s_cyc;
        chk("basic_first_latency", p1 - a_cyc, 4);
        chk("basic_gap1", p2 - p1, 4);
        chk("basic_gap2", p3 - p2, 4);
        drain("basic_drain", 40);
        chk("basic_time", s_time, 3);
        chk("basic_pulses", pulses, 3);
        chk("basic_remaining", s_rem, 0);
        chk("basic_busy", s_busy, 0);
        $display("basic run: pulses at %0d %0d %0d, time %0d", p1, p2, p3, s_time);

        // ---- table-driven accumulate/saturate runs ----
        for (int i = 0; i < 6; i++) begin
            clr();
            base = pulses;
            accept(vecs[i].a);
            accept(vecs[i].b);
            drain("vec_drain", 1100);
            chk("vec_time", s_time, vecs[i].exp_time);
            chk("vec_pulses", pulses - base, vecs[i].exp_time);
            chk("vec_remaining", s_rem, 0);
            $display("vector %0d: %0d + %0d -> time %0d", i, vecs[i].a, vecs[i].b, s_time);
        end

        // ---- quiet hold: one unit drops for one WAIT cycle ----
        clr();
        accept(3);
        wait_pulse("quiet_p1", 20, w); p1 = s_cyc;
        cyc(); cyc();
        done = 6'b111110; cyc(); done = ALL_DONE;
        wait_pulse("quiet_p2", 20, w); p2 = s_cyc;
        chk("quiet_gap", p2 - p1, 6);
        drain("quiet_drain", 40);
        $display("quiet hold: gap %0d", p2 - p1);

        // ---- update handshake ----
        clr();
        base = pulses;
        sent = 1'b0;
        accept(3);
`ifdef UCASPIAN_TIME_BACKPRESSURE_EN
        repeat (30) cyc();
        chk("bp_one_step", pulses - base, 1);
        chk("bp_update_held", s_upd, 1);
        sent = 1'b1; cyc(); sent = 1'b0;
        wait_pulse("bp_resume", HOLD + 2, w);
        sent = 1'b1;
        drain("bp_drain", 60);
        chk("bp_time", s_time, 3);
`else
        drain("nobp_drain", 60);
        chk("nobp_pulses", pulses - base, 3);
        chk("nobp_update_held", s_upd, 1);
        chk("nobp_time", s_time, 3);
        sent = 1'b1;
`endif
        $display("update handshake: time %0d, update %0d", s_time, s_upd);

        // ---- clear in BLANK after the 4th step ----
        clr();
        accept(10);
        for (int i = 0; i < 4; i++) wait_pulse("clr_pulse", 20, w);
        clear = 1'b1; cyc();
        chk("clr_rdy_low", s_rdy, 0);
        chk("clr_no_step", s_step, 0);
        clear = 1'b0; cyc();
        chk("clr_time", s_time, 0);
        chk("clr_update", s_upd, 0);
        chk("clr_busy", s_busy, 0);
        chk("clr_remaining", s_rem, 0);
        base = pulses;
        repeat (20) cyc();
        chk("clr_no_more_steps", pulses - base, 0);
        chk("clr_target_zero", s_rem, 0);
        $display("clear mid-run: time %0d", s_time);

        // ---- async reset asserted between edges during STEP ----
        clr();
        accept(3);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (next_step && time_current == TIME_W'(1)) found = 1;
        end
        chk("arst_found_step", found, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_step", next_step, 0);
        chk("arst_time", time_current, 0);
        chk("arst_update", time_update, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rdy", target_rdy, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        base = pulses;
        repeat (10) cyc();
        chk("arst_no_step", pulses - base, 0);
        chk("arst_time_after", s_time, 0);
        $display("async reset: time %0d after release", s_time);

        // ---- randomized run against a behavioural model ----
        clr();
        m_target = 0; m_time = 0; m_rem = 0; m_upd = 0; prev_upd = 0;
        last_low = s_cyc; last_clear = s_cyc; last_step = -100;
        for (int i = 0; i < 3000; i++) begin
            r_clear = ($urandom_range(0, 299) == 0) ? 1 : 0;
            r_vld   = ($urandom_range(0, 5) == 0) ? 1 : 0;
            r_tv    = $urandom_range(0, 6);
            r_sent  = $urandom_range(0, 1);
            clear = r_clear[0]; vld = r_vld[0]; tv = TGT_W'(r_tv); sent = r_sent[0];
            done = ($urandom_range(0, 3) != 0) ? ALL_DONE : NU'($urandom);
            cyc();
            t = s_cyc;
            chk("rnd_rdy", s_rdy, r_clear == 0 ? 1 : 0);
            chk("rnd_time", s_time, m_time);
            chk("rnd_remaining", s_rem, m_rem);
            chk("rnd_update", s_upd, m_upd);
            if (s_step) begin
                chk("rnd_step_below_target", (m_time < m_target) ? 1 : 0, 1);
                chk("rnd_step_spacing", (t - last_step >= HOLD + 3) ? 1 : 0, 1);
                chk("rnd_step_quiet", (t - 1 - HOLD > last_low) ? 1 : 0, 1);
                chk("rnd_step_after_clear", (t - last_clear >= 4) ? 1 : 0, 1);
                chk("rnd_step_busy", s_busy, 1);
`ifdef UCASPIAN_TIME_BACKPRESSURE_EN
                chk("rnd_step_backpressure", prev_upd, 0);
`endif
                last_step = t;
            end
            prev_upd = m_upd;
            if (done != ALL_DONE) last_low = t;
            if (r_clear != 0) begin
                m_target = 0; m_time = 0; m_rem = 0; m_upd = 0; last_clear = t;
            end else begin
                m_rem = (m_target > m_time) ? 1 : 0;
                if (r_vld != 0) begin
                    m_target = m_target + r_tv;
                    if (m_target > 255) m_target = 255;
                end
                if (s_step) begin
                    m_time = m_time + 1; m_upd = 1;
                end else if (r_sent != 0) begin
                    m_upd = 0;
                end
            end
        end
        clear = 1'b0; vld = 1'b0; sent = 1'b1; done = ALL_DONE;
        drain("rnd_drain", 1200);
        chk("rnd_final_time", s_time, m_target);
        $display("random run: final target %0d time %0d", m_target, s_time);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
